// File: rtl/hazard_detect_ctrl_if.sv
// Bubble-insert / pipeline-control bundle between the hazard controller (master)
// and the pipeline registers and ID-stage control mux (slave).
interface hazard_detect_ctrl_if #(
    parameter int REG_W = 5
);
    logic             idex_memread_i;
    logic [REG_W-1:0] idex_rt_i;
    logic [REG_W-1:0] ifid_rs_i;
    logic [REG_W-1:0] ifid_rt_i;
    logic             branch_taken_i;
    logic             mem_busy_i;
    logic             hd_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             pipe_en_o;
    logic             timeout_o;
    logic [15:0]      stall_cnt_o;

    modport master (
        input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
        input  branch_taken_i, mem_busy_i,
        output hd_o, pc_write_o, ifid_write_o, ifid_flush_o,
        output pipe_en_o, timeout_o, stall_cnt_o
    );

    modport slave (
        output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
        output branch_taken_i, mem_busy_i,
        input  hd_o, pc_write_o, ifid_write_o, ifid_flush_o,
        input  pipe_en_o, timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_detect_ctrl.sv
// Load-use / branch / memory-wait hazard controller for the 5-stage pipeline.
// Optional load-use bubble counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_detect_ctrl #(
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_detect_ctrl_if.master bus
);
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [REG_W-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             lu_s;
    logic             hd_s, pc_write_s, ifid_write_s, ifid_flush_s, pipe_en_s;

    // Load-use hazard: load in EX writes a non-zero register read by ID.
    always_comb begin
        lu_s = bus.idex_memread_i & (bus.idex_rt_i != ZERO_REG) &
               ((bus.idex_rt_i == bus.ifid_rs_i) | (bus.idex_rt_i == bus.ifid_rt_i));
    end

    // Next-state and control outputs; reset overrides outputs combinationally.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        hd_s         = 1'b0;
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        ifid_flush_s = 1'b0;
        pipe_en_s    = 1'b1;
        case (state_q)
            RUN: begin
                if (bus.mem_busy_i) begin
                    pipe_en_s    = 1'b0;
                    pc_write_s   = 1'b0;
                    ifid_write_s = 1'b0;
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (lu_s) begin
                    hd_s         = 1'b1;
                    pc_write_s   = 1'b0;
                    ifid_write_s = 1'b0;
                end else if (bus.branch_taken_i) begin
                    ifid_flush_s = 1'b1;
                end else begin
                    ifid_flush_s = 1'b0;
                end
            end
            MEM_WAIT: begin
                pipe_en_s    = 1'b0;
                pc_write_s   = 1'b0;
                ifid_write_s = 1'b0;
                if (bus.mem_busy_i) begin
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end else begin
                    // Release cycle stays frozen; RUN rules resume next cycle.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        timeout_d = timeout_q | (bus.mem_busy_i & (wait_cnt_d >= WAIT_LIM));
        if (rst_i) begin
            hd_s         = 1'b1;
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            ifid_flush_s = 1'b0;
            pipe_en_s    = 1'b0;
        end else begin
            hd_s = hd_s;
        end
    end

    // State, wait watchdog and sticky timeout registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count accepted load-use bubbles, saturating.
    always_comb begin
        if ((state_q == RUN) && lu_s && !bus.mem_busy_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
`else
    assign bus.stall_cnt_o = 16'h0000;
`endif

    assign bus.hd_o         = hd_s;
    assign bus.pc_write_o   = pc_write_s;
    assign bus.ifid_write_o = ifid_write_s;
    assign bus.ifid_flush_o = ifid_flush_s;
    assign bus.pipe_en_o    = pipe_en_s;
    assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_hazard_detect_ctrl.sv
// Self-checking bench for hazard_detect_ctrl: directed cases then random traffic
// against a rule-level reference model (MAX_WAIT overridden to 4).
module tb_hazard_detect_ctrl;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    bit   m_wait  = 1'b0;
    int   m_wcnt  = 0;
    bit   m_to    = 1'b0;
    int   m_sc    = 0;

    hazard_detect_ctrl_if #(.REG_W(5)) hif ();

    hazard_detect_ctrl #(.REG_W(5), .MAX_WAIT(MAXW), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input bit r, input bit mr, input int rt, input int rs,
                             input int rt2, input bit br, input bit busy);
        bit lu;
        int e_hd, e_pc, e_if, e_fl, e_pe;
        lu = mr && (rt != 0) && ((rt == rs) || (rt == rt2));
        if (r) begin
            e_hd = 1; e_pc = 0; e_if = 0; e_fl = 0; e_pe = 0;
        end else if (m_wait || busy) begin
            e_hd = 0; e_pc = 0; e_if = 0; e_fl = 0; e_pe = 0;
        end else if (lu) begin
            e_hd = 1; e_pc = 0; e_if = 0; e_fl = 0; e_pe = 1;
        end else begin
            e_hd = 0; e_pc = 1; e_if = 1; e_fl = br ? 1 : 0; e_pe = 1;
        end
        chk("hd_o", hif.hd_o, e_hd);
        chk("pc_write_o", hif.pc_write_o, e_pc);
        chk("ifid_write_o", hif.ifid_write_o, e_if);
        chk("ifid_flush_o", hif.ifid_flush_o, e_fl);
        chk("pipe_en_o", hif.pipe_en_o, e_pe);
        chk("timeout_o", hif.timeout_o, m_to);
`ifdef HAZARD_STALL_COUNT_EN
        chk("stall_cnt_o", hif.stall_cnt_o, m_sc);
`else
        chk("stall_cnt_o", hif.stall_cnt_o, 0);
`endif
    endtask

    task automatic step(input bit mr, input int rt, input int rs, input int rt2,
                        input bit br, input bit busy);
        bit lu;
        bit n_wait, n_to;
        int n_wcnt, n_sc;
        logic [4:0] v_rt, v_rs, v_rt2;
        @(negedge clk);
        v_rt = rt[4:0]; v_rs = rs[4:0]; v_rt2 = rt2[4:0];
        hif.idex_memread_i = mr;
        hif.idex_rt_i      = v_rt;
        hif.ifid_rs_i      = v_rs;
        hif.ifid_rt_i      = v_rt2;
        hif.branch_taken_i = br;
        hif.mem_busy_i     = busy;
        #1;
        check_all(1'b0, mr, rt, rs, rt2, br, busy);
        lu = mr && (rt != 0) && ((rt == rs) || (rt == rt2));
        n_wait = m_wait; n_wcnt = m_wcnt; n_to = m_to; n_sc = m_sc;
        if (m_wait) begin
            if (busy) n_wcnt = (m_wcnt < 255) ? m_wcnt + 1 : 255;
            else begin n_wait = 1'b0; n_wcnt = 0; end
        end else if (busy) begin
            n_wait = 1'b1; n_wcnt = 1;
        end else if (lu) begin
            n_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
        end
        if (busy && n_wcnt >= MAXW) n_to = 1'b1;
        @(posedge clk);
        #1;
        m_wait = n_wait; m_wcnt = n_wcnt; m_to = n_to; m_sc = n_sc;
    endtask

    // Asserts reset away from any clock edge, checks forced outputs, then releases.
    task automatic do_reset();
        hif.idex_memread_i = 1'b0;
        hif.idex_rt_i      = 5'd0;
        hif.ifid_rs_i      = 5'd0;
        hif.ifid_rt_i      = 5'd0;
        hif.branch_taken_i = 1'b0;
        hif.mem_busy_i     = 1'b0;
        rst = 1'b1;
        #1;
        m_wait = 1'b0; m_wcnt = 0; m_to = 1'b0; m_sc = 0;
        check_all(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        hif.idex_memread_i = 1'b0;
        hif.idex_rt_i      = 5'd0;
        hif.ifid_rs_i      = 5'd0;
        hif.ifid_rt_i      = 5'd0;
        hif.branch_taken_i = 1'b0;
        hif.mem_busy_i     = 1'b0;
        #2;
        check_all(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 0, 0, 0, 1'b0, 1'b0);

        // load-use bubble, then release
        step(1'b1, 5, 5, 0, 1'b0, 1'b0);
        step(1'b0, 5, 5, 0, 1'b0, 1'b0);
        // r0 never causes a bubble
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        // load-use wins over branch; branch alone flushes
        step(1'b1, 7, 3, 7, 1'b1, 1'b0);
        step(1'b0, 7, 3, 7, 1'b1, 1'b0);
        // short memory wait, no timeout
        repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 0, 0, 0, 1'b0, 1'b0);
        // mid-operation reset during a stall
        step(1'b1, 9, 9, 1, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 0, 0, 0, 1'b0, 1'b0);
        // long wait trips the sticky timeout
        repeat (6) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        repeat (2) step(1'b1, 2, 2, 2, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 0, 0, 0, 1'b0, 1'b0);

        // random traffic with narrow register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 5) == 0) || (m_wait && $urandom_range(0, 2) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
